// File: rtl/ce_sync_pkg.sv
// Shared constants and the nibble-wise data transform for the ce_sync_pipe slice.
package ce_sync_pkg;

    localparam int unsigned DEF_WIDTH       = 4;
    localparam int unsigned DEF_STAGES      = 2;
    localparam int unsigned DEF_DIV_W       = 4;
    localparam int unsigned DEF_DEFAULT_DIV = 4;

    localparam int unsigned NIB_W       = 4;
    localparam int unsigned XFORM_MAX_W = 64;

    // Per-nibble transform applied by every pipeline stage.
    function automatic logic [NIB_W-1:0] nib_xform(input logic [NIB_W-1:0] x);
        logic [NIB_W-1:0] y;
        y[3] = x[3] | x[1];
        y[2] = x[2] & x[1];
        y[1] = x[1];
        y[0] = x[1] & x[0];
        return y;
    endfunction

    // Word-wide wrapper; callers zero-extend to XFORM_MAX_W and truncate the result.
    function automatic logic [XFORM_MAX_W-1:0] word_xform(input logic [XFORM_MAX_W-1:0] x);
        logic [XFORM_MAX_W-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < XFORM_MAX_W / NIB_W; i++) begin
            y[i*NIB_W +: NIB_W] = nib_xform(x[i*NIB_W +: NIB_W]);
        end
        return y;
    endfunction

endpackage

// File: rtl/ce_sync_pipe_ce_gen.sv
// Programmable clock-enable generator: one-cycle ce strobe every N fast_clk cycles,
// with a pending ratio that only takes effect on a period boundary.
module ce_gen
    import ce_sync_pkg::*;
#(
    parameter int unsigned DIV_W       = DEF_DIV_W,
    parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
    input  logic             fast_clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             ce
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic             RST_CE  = 1'(DEFAULT_DIV <= 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] act_q;
    logic [DIV_W-1:0] act_d;
    logic [DIV_W-1:0] pend_q;
    logic [DIV_W-1:0] pend_d;
    logic             ce_q;
    logic             ce_d;

    // Terminal count for a stored ratio; ratio 0 behaves as ratio 1.
    function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] r);
        return (r == '0) ? '0 : r - DIV_W'(1);
    endfunction

    // ce is the registered image of (cnt == N-1), computed from next-state values.
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        cnt_d  = cnt_q + DIV_W'(1);
        if (div_load) begin
            pend_d = div_ratio;
        end
        if (ce_q) begin
            act_d = pend_d;
            cnt_d = '0;
        end
        ce_d = (cnt_d == last_count(act_d));
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= RST_DIV;
            pend_q <= RST_DIV;
            ce_q   <= RST_CE;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            ce_q   <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/ce_sync_pipe.sv
// Sub-rate pipeline: valid-qualified hold register with overrun detection, a synch
// register and STAGES transform stages, all advancing only on the ce strobe.
module ce_sync_pipe
    import ce_sync_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned STAGES      = DEF_STAGES,
    parameter int unsigned DIV_W       = DEF_DIV_W,
    parameter int unsigned DEFAULT_DIV = DEF_DEFAULT_DIV
) (
    input  logic             fast_clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_vld,
    input  logic             ovr_clr,
    output logic             ce,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    output logic             overrun
);

    if (WIDTH == 0 || (WIDTH % NIB_W) != 0 || WIDTH > XFORM_MAX_W) begin : g_bad_width
        $error("ce_sync_pipe: WIDTH must be a non-zero multiple of 4, at most 64");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("ce_sync_pipe: STAGES must be at least 1");
    end
    if (DEFAULT_DIV < 1) begin : g_bad_div
        $error("ce_sync_pipe: DEFAULT_DIV must be at least 1");
    end

    function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] x);
        return WIDTH'(word_xform(XFORM_MAX_W'(x)));
    endfunction

    logic [WIDTH-1:0] hold_q;
    logic             hold_vld_q;
    logic             overrun_q;
    logic [WIDTH-1:0] synch_q;
    logic             synch_vld_q;
    logic             out_vld_q;

    ce_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ce_gen (
        .fast_clk  (fast_clk),
        .rst_n     (rst_n),
        .div_ratio (div_ratio),
        .div_load  (div_load),
        .ce        (ce)
    );

    // Hold register: latest sample wins; a ce edge drains it even when a new one lands.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (data_vld) begin
                hold_q <= data_in;
            end
            if (data_vld) begin
                hold_vld_q <= 1'b1;
            end else if (ce) begin
                hold_vld_q <= 1'b0;
            end
            if (data_vld && hold_vld_q && !ce) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            synch_q     <= '0;
            synch_vld_q <= 1'b0;
        end else if (ce) begin
            synch_q     <= hold_q;
            synch_vld_q <= hold_vld_q;
        end
    end

    // Stage-to-stage paths only toggle on ce, so they are N-cycle multicycle paths.
    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic [WIDTH-1:0] din;
        logic             din_vld;
        logic [WIDTH-1:0] data_q;
        logic             vld_q;

        if (k == 0) begin : g_first
            assign din     = synch_q;
            assign din_vld = synch_vld_q;
        end else begin : g_next
            assign din     = g_stage[k-1].data_q;
            assign din_vld = g_stage[k-1].vld_q;
        end

        always_ff @(posedge fast_clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= 1'b0;
            end else if (ce) begin
                data_q <= xform(din);
                vld_q  <= din_vld;
            end
        end
    end

    // One-cycle pulse following the ce edge that loads a valid result into the last stage.
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= ce & g_stage[STAGES-1].din_vld;
        end
    end

    assign out_data = g_stage[STAGES-1].data_q;
    assign out_vld  = out_vld_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_ce_sync_pipe.sv
// Scoreboard bench for ce_sync_pipe: directed stimulus pushes expected results,
// a negedge monitor pops and compares on every out_vld.
module tb_ce_sync_pipe;

    localparam int unsigned WIDTH       = 4;
    localparam int unsigned STAGES      = 2;
    localparam int unsigned DIV_W       = 4;
    localparam int unsigned DEFAULT_DIV = 4;

    logic             fast_clk  = 1'b0;
    logic             rst_n     = 1'b0;
    logic [DIV_W-1:0] div_ratio = '0;
    logic             div_load  = 1'b0;
    logic [WIDTH-1:0] data_in   = '0;
    logic             data_vld  = 1'b0;
    logic             ovr_clr   = 1'b0;
    logic             ce;
    logic [WIDTH-1:0] out_data;
    logic             out_vld;
    logic             overrun;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int pulse_cnt  = 0;
    int last_pulse = 0;
    int prev_pulse = 0;
    logic [WIDTH-1:0] sb [$];

    ce_sync_pipe #(
        .WIDTH       (WIDTH),
        .STAGES      (STAGES),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .fast_clk  (fast_clk),
        .rst_n     (rst_n),
        .div_ratio (div_ratio),
        .div_load  (div_load),
        .data_in   (data_in),
        .data_vld  (data_vld),
        .ovr_clr   (ovr_clr),
        .ce        (ce),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .overrun   (overrun)
    );

    always #5 fast_clk = ~fast_clk;

    always @(posedge fast_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic wait_ce(input string name);
        int n;
        n = 0;
        while (ce !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ce !== 1'b1) begin
            failures++;
            $display("FAIL %s: ce=%b expected 1 within 20 cycles", name, ce);
        end
    endtask

    // Monitor: every out_vld must match the oldest queued expectation.
    always @(negedge fast_clk) begin
        if (rst_n && out_vld === 1'b1) begin
            pulse_cnt++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_vld: got out_data %0h with empty scoreboard at cycle %0d", out_data, cyc);
            end else begin
                logic [WIDTH-1:0] exp;
                exp = sb.pop_front();
                checks--;
                check("out_data", 32'(out_data), 32'(exp));
            end
        end
    end

    initial begin
        int p0;
        int pat2 [6] = '{0, 1, 0, 1, 0, 1};

        // Reset state
        repeat (2) @(posedge fast_clk);
        #1;
        check("rst_ce", 32'(ce), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;

        // Default ratio 4: ce in cycles 3, 7, 11 after release
        for (int i = 0; i < 12; i++) begin
            check($sformatf("default_ce_%0d", i), 32'(ce), 32'((i % 4) == 3));
            check($sformatf("default_out_data_%0d", i), 32'(out_data), 0);
            tick();
        end

        // Ratio 1 loaded on a ce edge applies immediately; latency E+3
        wait_ce("wait_ce_ratio1");
        div_ratio = 4'd1;
        div_load  = 1'b1;
        tick();
        div_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ratio1_ce_%0d", i), 32'(ce), 1);
            tick();
        end
        data_in  = 4'b0111;
        data_vld = 1'b1;
        sb.push_back(4'b1111);
        tick();
        data_vld = 1'b0;
        check("lat_e0_out_vld", 32'(out_vld), 0);
        tick();
        check("lat_e1_out_vld", 32'(out_vld), 0);
        tick();
        check("lat_e2_out_vld", 32'(out_vld), 0);
        tick();
        check("lat_e3_out_vld", 32'(out_vld), 1);
        check("lat_e3_out_data", 32'(out_data), 32'(4'b1111));
        tick();
        check("lat_e4_out_vld", 32'(out_vld), 0);

        // Back to ratio 4; two samples in one period -> overrun, one result
        wait_ce("wait_ce_ratio4");
        div_ratio = 4'd4;
        div_load  = 1'b1;
        tick();
        div_load = 1'b0;
        check("ratio4_ce_after_load", 32'(ce), 0);
        p0 = pulse_cnt;
        data_in  = 4'b0110;
        data_vld = 1'b1;
        tick();
        data_in = 4'b1001;
        sb.push_back(4'b1000);
        tick();
        data_vld = 1'b0;
        check("overrun_set", 32'(overrun), 1);
        repeat (14) tick();
        check("overrun_sticky", 32'(overrun), 1);
        check("overrun_pulses", 32'(pulse_cnt - p0), 1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("overrun_cleared", 32'(overrun), 0);

        // Sample coincident with a ce edge while hold is valid: no overrun, two results 4 apart
        wait_ce("wait_ce_coinc_sync");
        tick();
        p0 = pulse_cnt;
        data_in  = 4'b0111;
        data_vld = 1'b1;
        sb.push_back(4'b1111);
        tick();
        data_vld = 1'b0;
        wait_ce("wait_ce_coinc");
        data_in  = 4'b0110;
        data_vld = 1'b1;
        sb.push_back(4'b1110);
        tick();
        data_vld = 1'b0;
        check("coinc_no_overrun", 32'(overrun), 0);
        repeat (16) tick();
        check("coinc_pulses", 32'(pulse_cnt - p0), 2);
        check("coinc_spacing", 32'(last_pulse - prev_pulse), 4);

        // Load 2 at cnt=1: period finishes at cnt=3, then every 2; then load 0 -> every cycle
        wait_ce("wait_ce_div2");
        tick();
        tick();
        div_ratio = 4'd2;
        div_load  = 1'b1;
        tick();
        div_load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("div2_ce_%0d", i), 32'(ce), 32'(pat2[i]));
            tick();
        end
        div_ratio = 4'd0;
        div_load  = 1'b1;
        tick();
        div_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("div0_ce_%0d", i), 32'(ce), 1);
            tick();
        end

        // Reset with a valid sample in stage1: outputs clear at once, no pulse afterwards
        p0 = pulse_cnt;
        data_in  = 4'b0111;
        data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_data", 32'(out_data), 0);
        check("midrst_out_vld", 32'(out_vld), 0);
        check("midrst_overrun", 32'(overrun), 0);
        check("midrst_ce", 32'(ce), 0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("midrst_no_pulse", 32'(pulse_cnt - p0), 0);
        check("midrst_out_data_after", 32'(out_data), 0);
        check("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ce_sync_pipe.md
# ce_sync_pipe

Parametrised successor to the fixed divide-by-4 sync counter. A single-clock pipeline: a programmable clock-enable generator replaces the derived slow clock, and an N-stage multicycle transform pipeline advances only on the enable strobe. Input capture uses a valid-qualified holding register with overrun detection. It sits between a fast-domain data source and consumers that run at a programmable sub-rate of `fast_clk`.

## Interface
- `WIDTH`, 4: data width; must be a multiple of 4.
- `STAGES`, 2: transform stages after the synch register; must be ≥ 1.
- `DIV_W`, 4: divide-ratio width.
- `DEFAULT_DIV`, 4: divide ratio after reset; must be ≥ 1.

Ports:
- `fast_clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `div_ratio`  in  DIV_W  requested divide ratio N; 0 is treated as 1.
- `div_load`  in  1  latch `div_ratio` as the pending ratio.
- `data_in`  in  WIDTH  input sample.
- `data_vld`  in  1  `data_in` valid this cycle.
- `ovr_clr`  in  1  clear the sticky overrun flag.
- `ce`  out  1  enable strobe, high one cycle in every N.
- `out_data`  out  WIDTH  last stage register.
- `out_vld`  out  1  one-cycle pulse: new valid result in `out_data`.
- `overrun`  out  1  sticky flag: a held sample was overwritten before transfer.

## Operation
- Enable generator: counter `cnt` runs 0..N-1. `ce` = (`cnt` == N-1), decoded from registered state only. At a `ce` edge, `cnt` returns to 0; otherwise it increments.
- Ratio update: `div_load` at an edge stores the pending ratio, and the last load wins. The active ratio takes the pending value only at a `ce` edge; if that edge is also the load edge, the new value applies immediately. The current period is never truncated or extended.
- Hold register: `data_vld` at an edge loads `hold` ← `data_in` and sets `hold_vld`. At a `ce` edge, `synch` ← `hold`, `synch_vld` ← `hold_vld`, and `hold_vld` is cleared.
- Simultaneous `ce` and `data_vld`: the old hold transfers, the new sample loads, `hold_vld` stays 1, and no overrun is raised.
- Overrun: `data_vld` while `hold_vld` = 1 and `ce` = 0 overwrites the sample (latest wins) and sets `overrun`. `ovr_clr` clears it. If set and clear coincide, set wins.
- Pipeline: at each `ce` edge, stage1 ← f(`synch`) and stage k ← f(stage k-1); valid bits travel alongside the data. Between `ce` edges all stages hold. Every stage-to-stage path is a multicycle path of N cycles.
- f, applied per 4-bit nibble x → y:
  - y3 = x3|x1
  - y2 = x2&x1
  - y1 = x1
  - y0 = x1&x0
- `out_vld` is 1 for exactly one cycle after a `ce` edge that loads the last stage with valid = 1; otherwise it is 0.

## Timing
- Reset values:
  - `cnt` = 0 and active/pending ratio = `DEFAULT_DIV`.
  - `hold`, `synch`, all stages and `out_data` = 0.
  - All valid bits, `out_vld` and `overrun` = 0.
- `ce` is high for `cnt` == N-1 after reset; for N = 4 it first rises in the 4th cycle after reset release.
- Latency: a sample captured at edge E reaches `synch` at the first `ce` edge after E (strictly later). It reaches `out_data` STAGES `ce` edges after that.
  - N = 1: `out_data` updates at edge E+1+STAGES and `out_vld` is high in the following cycle.
- Throughput: at most one sample per N cycles without overrun.
- Ratio 0 behaves identically to ratio 1.
- Reset asserted mid-operation: all state clears asynchronously and no `out_vld` is emitted for in-flight samples.

## Structure
- Package `ce_sync_pkg`:
  - nibble transform function f and its WIDTH-wide wrapper;
  - default constants for WIDTH, STAGES, DIV_W and DEFAULT_DIV.
- Sub-module `ce_gen`: counter, active/pending ratio registers and the `ce` decode.
- Top `ce_sync_pipe`: hold/overrun logic, `synch` register, generate-loop stage array and `out_vld` generation.

## Test plan
- Reset, no load (N = 4): `ce` pulses in cycles 3, 7, 11, … after release; `out_vld` = 0 and `out_data` = 0.
- `div_load` with ratio 1, then `data_vld` with `data_in` = 4'b0111 at edge E → `out_data` = 4'b1111 at edge E+3; `out_vld` is a single pulse in the next cycle.
- N = 4, `data_vld` for 4'b0110 then 4'b1001 within one period → `overrun` = 1 and exactly one `out_vld`, with `out_data` = 4'b1000. `ovr_clr` then returns `overrun` to 0.
- N = 4, `data_vld` coincident with a `ce` edge while `hold_vld` = 1 → no overrun, and two consecutive results are emitted 4 cycles apart.
- N = 4, `div_load` with 2 at `cnt` = 1 → next `ce` still at `cnt` = 3, then every 2 cycles; `div_load` with 0 → `ce` every cycle.
- Assert `rst_n` low while a valid sample is in stage1 → all outputs 0 immediately, and no `out_vld` pulse after release.
